// File: rtl/shim_rd_arbiter.sv
// Read-request arbiter for the AXI shim; SHIM_RD_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: zero-cycle combinational request/grant and response routing; only FSM, pointer and counters are registered.
// Backpressure: a stalled shim grant freezes the selection; responses stall on the addressed client's rdy_i.
module shim_rd_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned AxiNumWords    = 4,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NumPorts-1:0]                            req_i,
    output logic [NumPorts-1:0]                            gnt_o,
    input  logic [NumPorts-1:0][63:0]                      addr_i,
    input  logic [NumPorts-1:0][$clog2(AxiNumWords)-1:0]   blen_i,
    input  logic [NumPorts-1:0][1:0]                       size_i,
    input  logic [NumPorts-1:0]                            lock_i,
    output logic [NumPorts-1:0]                            valid_o,
    output logic                                           last_o,
    output logic [63:0]                                    data_o,
    output logic                                           exokay_o,
    input  logic [NumPorts-1:0]                            rdy_i,
    output logic                                           shim_req_o,
    input  logic                                           shim_gnt_i,
    output logic [63:0]                                    shim_addr_o,
    output logic [$clog2(AxiNumWords)-1:0]                 shim_blen_o,
    output logic [1:0]                                     shim_size_o,
    output logic                                           shim_lock_o,
    output logic [AxiIdWidth-1:0]                          shim_id_o,
    output logic                                           shim_rdy_o,
    input  logic                                           shim_valid_i,
    input  logic                                           shim_last_i,
    input  logic                                           shim_exokay_i,
    input  logic [63:0]                                    shim_data_i,
    input  logic [AxiIdWidth-1:0]                          shim_id_i,
    output logic                                           err_o
);

    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW  = 3;
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [PortW-1:0]    sel_q, sel_d, ptr_q, ptr_d, pick, cur, cand;
    logic [PortW:0]      sum;
    logic [CntW-1:0]     cnt_q [NumPorts];
    logic [NumPorts-1:0] elig, inc_hit, dec_hit, cnt_zero;
    logic                any_elig, inc_vld, id_ok, dec_vld, underflow;
    logic [PortW-1:0]    rsp_idx;
    logic [31:0]         id_ext;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            elig[p]     = req_i[p] && (cnt_q[p] < MaxOut);
            cnt_zero[p] = (cnt_q[p] == '0);
        end
    end

    // Search upward from ptr_q with wrap; the first eligible candidate wins.
    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = 0; i < NumPorts; i++) begin
            sum = (PortW+1)'(ptr_q) + (PortW+1)'(i);
            if (sum >= (PortW+1)'(NumPorts)) begin
                sum = sum - (PortW+1)'(NumPorts);
            end
            cand = sum[PortW-1:0];
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        cur        = pick;
        shim_req_o = 1'b0;
        gnt_o      = '0;
        inc_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    shim_req_o = 1'b1;
                    if (shim_gnt_i) begin
                        gnt_o[pick] = 1'b1;
                        inc_vld     = 1'b1;
                    end else begin
                        sel_d   = pick;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Selection is frozen until granted so the AR payload stays stable.
                cur        = sel_q;
                shim_req_o = 1'b1;
                if (shim_gnt_i) begin
                    gnt_o[sel_q] = 1'b1;
                    inc_vld      = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (inc_vld) begin
            ptr_d = (cur == PortW'(NumPorts - 1)) ? '0 : cur + PortW'(1);
        end
    end

    assign shim_addr_o = shim_req_o ? addr_i[cur] : '0;
    assign shim_blen_o = shim_req_o ? blen_i[cur] : '0;
    assign shim_size_o = shim_req_o ? size_i[cur] : '0;
    assign shim_lock_o = shim_req_o && lock_i[cur];
    assign shim_id_o   = shim_req_o ? AxiIdWidth'(cur) : '0;

    assign id_ext  = 32'(shim_id_i);
    assign id_ok   = (id_ext < NumPorts);
    assign rsp_idx = shim_id_i[PortW-1:0];

    // Beats with an unknown ID are sunk so the shim never deadlocks on them.
    always_comb begin
        valid_o    = '0;
        shim_rdy_o = 1'b1;
        if (id_ok) begin
            valid_o[rsp_idx] = shim_valid_i;
            shim_rdy_o       = rdy_i[rsp_idx];
        end
    end

    assign last_o   = shim_last_i;
    assign data_o   = shim_data_i;
    assign exokay_o = shim_exokay_i;
    assign dec_vld  = shim_valid_i && shim_rdy_o && shim_last_i && id_ok;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            inc_hit[p] = inc_vld && (cur == PortW'(p));
            dec_hit[p] = dec_vld && (rsp_idx == PortW'(p));
        end
    end

    assign underflow = |(dec_hit & ~inc_hit & cnt_zero);
    assign err_o     = (shim_valid_i && !id_ok) || underflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (inc_hit[p] && !dec_hit[p]) begin
                    cnt_q[p] <= cnt_q[p] + CntW'(1);
                end else if (dec_hit[p] && !inc_hit[p] && !cnt_zero[p]) begin
                    cnt_q[p] <= cnt_q[p] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef SHIM_RD_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
`endif

endmodule

// File: tb/tb_shim_rd_arbiter.sv
// Bench for shim_rd_arbiter: directed scenarios followed by random traffic against a reference model.
module tb_shim_rd_arbiter;
    localparam int N    = 2;
    localparam int MAXO = 2;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic [N-1:0]       req = '0, gnt_o, valid_o, rdy = '0;
    logic [N-1:0][63:0] addr = '0;
    logic [N-1:0][1:0]  blen = '0, size = '0;
    logic [N-1:0]       lock = '0;
    logic               last_o, exokay_o, shim_req_o, shim_rdy_o, shim_lock_o, err_o;
    logic [63:0]        data_o, shim_addr_o, shim_data = '0;
    logic [1:0]         shim_blen_o, shim_size_o;
    logic [3:0]         shim_id_o, shim_id = '0;
    logic               shim_gnt = 1'b0, shim_valid = 1'b0, shim_last = 1'b0, shim_exokay = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: outstanding bursts, RR pointer, port held awaiting grant (-1 = none).
    int m_cnt [N];
    int m_ptr;
    int m_held;

    shim_rd_arbiter #(.NumPorts(N), .AxiNumWords(4), .AxiIdWidth(4), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt_o), .addr_i(addr), .blen_i(blen),
        .size_i(size), .lock_i(lock), .valid_o(valid_o), .last_o(last_o), .data_o(data_o),
        .exokay_o(exokay_o), .rdy_i(rdy), .shim_req_o(shim_req_o), .shim_gnt_i(shim_gnt),
        .shim_addr_o(shim_addr_o), .shim_blen_o(shim_blen_o), .shim_size_o(shim_size_o),
        .shim_lock_o(shim_lock_o), .shim_id_o(shim_id_o), .shim_rdy_o(shim_rdy_o),
        .shim_valid_i(shim_valid), .shim_last_i(shim_last), .shim_exokay_i(shim_exokay),
        .shim_data_i(shim_data), .shim_id_i(shim_id), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) m_cnt[p] = 0;
        m_ptr  = 0;
        m_held = -1;
    endtask

    function automatic int exp_port();
        if (m_held >= 0) return m_held;
        for (int i = 0; i < N; i++) begin
            int p = (m_ptr + i) % N;
            if (req[p] && m_cnt[p] < MAXO) return p;
        end
        return -1;
    endfunction

    function automatic bit rsp_id_ok();
        return int'(shim_id) < N;
    endfunction

    function automatic bit exp_rdy();
        return rsp_id_ok() ? rdy[int'(shim_id)] : 1'b1;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        req = '0; shim_gnt = 0; shim_valid = 0; shim_last = 0; shim_exokay = 0;
        shim_data = '0; shim_id = '0; rdy = '0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    // Compare every output against the model at the falling edge.
    task automatic eval(input string tag);
        int ep, id;
        bit ok, dec, er;
        logic [N-1:0] eg, ev;
        @(negedge clk);
        ep = exp_port();
        eg = '0;
        if (ep >= 0 && shim_gnt) eg[ep] = 1'b1;
        check({tag, ".shim_req"}, 64'(shim_req_o), 64'(ep >= 0));
        check({tag, ".gnt"}, 64'(gnt_o), 64'(eg));
        if (ep >= 0) begin
            check({tag, ".addr"}, shim_addr_o, addr[ep]);
            check({tag, ".blen"}, 64'(shim_blen_o), 64'(blen[ep]));
            check({tag, ".size"}, 64'(shim_size_o), 64'(size[ep]));
            check({tag, ".lock"}, 64'(shim_lock_o), 64'(lock[ep]));
            check({tag, ".id"}, 64'(shim_id_o), 64'(ep));
        end
        id = int'(shim_id);
        ok = rsp_id_ok();
        ev = '0;
        if (ok && shim_valid) ev[id] = 1'b1;
        dec = shim_valid && exp_rdy() && shim_last && ok;
        er = (shim_valid && !ok) || (dec && m_cnt[id] == 0 && !(ep == id && shim_gnt));
        check({tag, ".valid"}, 64'(valid_o), 64'(ev));
        check({tag, ".shim_rdy"}, 64'(shim_rdy_o), 64'(exp_rdy()));
        check({tag, ".err"}, 64'(err_o), 64'(er));
        if (shim_valid) begin
            check({tag, ".last"}, 64'(last_o), 64'(shim_last));
            check({tag, ".data"}, data_o, shim_data);
            check({tag, ".exokay"}, 64'(exokay_o), 64'(shim_exokay));
        end
    endtask

    task automatic adv();
        int ep, id;
        bit granted, dec;
        @(posedge clk);
        ep = exp_port();
        granted = (ep >= 0) && shim_gnt;
        id = int'(shim_id);
        dec = shim_valid && exp_rdy() && shim_last && rsp_id_ok();
        if (ep >= 0) begin
            if (shim_gnt) begin
                m_ptr  = (ep + 1) % N;
                m_held = -1;
            end else begin
                m_held = ep;
            end
        end
        if (granted && !(dec && id == ep)) m_cnt[ep]++;
        if (dec && !(granted && id == ep) && m_cnt[id] > 0) m_cnt[id]--;
        #1;
    endtask

    initial begin
        model_reset();
        #3;
        check("rst.gnt", 64'(gnt_o), 64'd0);
        check("rst.shim_req", 64'(shim_req_o), 64'd0);
        check("rst.valid", 64'(valid_o), 64'd0);
        check("rst.err", 64'(err_o), 64'd0);
        do_reset();
        addr[0] = 64'h1000; addr[1] = 64'h2000;
        blen[0] = 2'd3; blen[1] = 2'd1; size[0] = 2'd3; size[1] = 2'd2; lock = 2'b10;

        // 1: alternating grants until both ports hit the outstanding limit
        req = 2'b11; shim_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eval("t1");
            check("t1.gnt_seq", 64'(gnt_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            check("t1.id_seq", 64'(shim_id_o), 64'(k % 2));
            adv();
        end
        eval("t1");
        check("t1.both_masked", 64'(shim_req_o), 64'd0);
        adv();

        // 2: selection held while the shim stalls
        do_reset();
        req = 2'b10; shim_gnt = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) req = 2'b11;
            eval("t2");
            check("t2.addr_hold", shim_addr_o, 64'h2000);
            check("t2.no_gnt", 64'(gnt_o), 64'd0);
            adv();
        end
        shim_gnt = 1'b1;
        eval("t2");
        check("t2.gnt1", 64'(gnt_o), 64'd2);
        adv();
        req = 2'b01;
        eval("t2");
        check("t2.gnt0_next", 64'(gnt_o), 64'd1);
        check("t2.addr0", shim_addr_o, 64'h1000);
        adv();

        // 3: outstanding limit masks a lone requester until a last beat returns
        do_reset();
        req = 2'b01; shim_gnt = 1'b1;
        repeat (2) begin
            eval("t3");
            check("t3.gnt", 64'(gnt_o), 64'd1);
            adv();
        end
        eval("t3");
        check("t3.masked", 64'(shim_req_o), 64'd0);
        adv();
        shim_valid = 1; shim_last = 1; shim_id = 4'd0; rdy = 2'b01; shim_data = 64'hABCD;
        eval("t3");
        check("t3.still_masked", 64'(shim_req_o), 64'd0);
        check("t3.valid", 64'(valid_o), 64'd1);
        adv();
        shim_valid = 0; shim_last = 0;
        eval("t3");
        check("t3.regrant", 64'(gnt_o), 64'd1);
        adv();
        req = '0;

        // 4: multi-beat response with client backpressure
        do_reset();
        req = 2'b10; shim_gnt = 1'b1;
        repeat (2) begin eval("t4g"); adv(); end
        shim_gnt = 1'b0;
        for (int b = 0; b < 5; b++) begin
            shim_valid = 1; shim_id = 4'd1; rdy[1] = (b != 1); shim_last = (b == 4);
            shim_data = {$urandom, $urandom};
            eval("t4");
            check("t4.valid", 64'(valid_o), 64'd2);
            check("t4.rdy_mirror", 64'(shim_rdy_o), (b != 1) ? 64'd1 : 64'd0);
            check("t4.masked", 64'(shim_req_o), 64'd0);
            adv();
        end
        shim_valid = 0; shim_last = 0;
        eval("t4");
        check("t4.unmasked", 64'(shim_req_o), 64'd1);
        adv();

        // 5: response with an out-of-range ID is sunk and flagged
        do_reset();
        shim_valid = 1; shim_id = 4'd3; rdy = 2'b00; shim_last = 1;
        eval("t5");
        check("t5.rdy", 64'(shim_rdy_o), 64'd1);
        check("t5.valid", 64'(valid_o), 64'd0);
        check("t5.err", 64'(err_o), 64'd1);
        adv();
        shim_valid = 0; shim_last = 0;
        eval("t5");
        check("t5.err_clear", 64'(err_o), 64'd0);
        adv();

        // 6: asynchronous reset during HOLD with outstanding bursts
        do_reset();
        shim_gnt = 1'b1;
        req = 2'b01; eval("t6"); adv();
        req = 2'b10; eval("t6"); adv();
        eval("t6"); adv();
        req = 2'b11; shim_gnt = 1'b0;
        eval("t6");
        check("t6.hold_sel", 64'(shim_id_o), 64'd0);
        adv();
        #2;
        rst_ni = 1'b0;
        req = '0; rdy = '0; shim_valid = 0; shim_last = 0; shim_id = '0; shim_data = '0;
        #1;
        check("t6.rst_gnt", 64'(gnt_o), 64'd0);
        check("t6.rst_req", 64'(shim_req_o), 64'd0);
        check("t6.rst_addr", shim_addr_o, 64'd0);
        check("t6.rst_id", 64'(shim_id_o), 64'd0);
        check("t6.rst_valid", 64'(valid_o), 64'd0);
        check("t6.rst_err", 64'(err_o), 64'd0);
        check("t6.rst_data", data_o, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        req = 2'b11; shim_gnt = 1'b1;
        eval("t6");
        check("t6.post_gnt0", 64'(gnt_o), 64'd1);
        adv();
        eval("t6");
        check("t6.post_gnt1", 64'(gnt_o), 64'd2);
        adv();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            if (m_held >= 0) req[m_held] = 1'b1;
            shim_gnt = 1'($urandom);
            for (int p = 0; p < N; p++) begin
                addr[p] = {$urandom, $urandom};
                blen[p] = 2'($urandom);
                size[p] = 2'($urandom);
                lock[p] = 1'($urandom);
            end
            rdy         = N'($urandom);
            shim_valid  = 1'($urandom);
            shim_last   = 1'($urandom);
            shim_exokay = 1'($urandom);
            shim_id     = 4'($urandom_range(0, 3));
            shim_data   = {$urandom, $urandom};
            eval("rnd");
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
